// File: rtl/icache_sa_fetch.sv
// Set-associative instruction cache with a whole-line refill FSM in front of the memory controller.
// Define ICACHE_PERF_EN to add the hit_cnt / miss_cnt performance counters.
module icache_sa_fetch #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OFF    = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t state, next_state;

  logic [WAYS-1:0]   valid   [SETS];
  logic [WAY_W-1:0]  rr      [SETS];
  logic [TAG_W-1:0]  tag_mem [SETS][WAYS];
  logic [INST_W-1:0] data_mem[SETS][WAYS][LINE_WORDS];
  logic [INST_W-1:0] line_buf[LINE_WORDS];

  logic [ADDR_W-1:0] line_addr;
  logic [BEAT_W-1:0] beat;
  logic [WAY_W-1:0]  vway;
  logic              poison;

  logic [IDX_W-1:0]  idx, line_idx;
  logic [TAG_W-1:0]  tag, line_tag;
  logic [BEAT_W-1:0] word_sel;
  logic [WAYS-1:0]   hit_vec;
  logic [INST_W-1:0] hit_word;
  logic              hit;
  logic [WAY_W-1:0]  victim;
  logic              found;
  logic              start, beat_ack, fill_ok;
  logic              unused_bits;

  assign idx      = pc[OFF +: IDX_W];
  assign tag      = pc[ADDR_W-1 -: TAG_W];
  assign line_idx = line_addr[OFF +: IDX_W];
  assign line_tag = line_addr[ADDR_W-1 -: TAG_W];
  assign unused_bits = ^{pc[1:0], line_addr[OFF-1:0]};

  if (LINE_WORDS > 1) begin : g_wsel
    assign word_sel = pc[OFF-1:2];
  end else begin : g_wsel_one
    assign word_sel = '0;
  end

  // Lookup: tag compare across all ways of the indexed set, OR-mux of the hitting way
  always_comb begin
    hit_vec  = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid[idx][w] && (tag_mem[idx][w] == tag);
      if (hit_vec[w]) hit_word = hit_word | data_mem[idx][w][word_sel];
    end
  end

  assign hit    = rst && (|hit_vec);
  assign stall  = !hit;
  assign pc_o   = hit ? pc : '0;
  assign inst_o = hit ? hit_word : '0;

  // Victim: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    victim = rr[idx];
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[idx][w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  assign start    = (state == IDLE) && rdy && !flush && !hit;
  assign beat_ack = (state == REFILL) && rdy && mem_ack;
  assign fill_ok  = (state == DONE) && rdy && !poison && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (rdy) begin
      case (state)
        IDLE:    if (!hit && !flush) next_state = REFILL;
        REFILL:  if (mem_ack && (beat == LAST_BEAT)) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req = (state == REFILL);
  end

  assign mem_addr = line_addr | ADDR_W'({beat, 2'b00});

  // Control state: refill bookkeeping, valid bits and replacement pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_addr <= '0;
      beat      <= '0;
      vway      <= '0;
      poison    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else if (rdy) begin
      if (start) begin
        line_addr <= {pc[ADDR_W-1:OFF], {OFF{1'b0}}};
        beat      <= '0;
        vway      <= victim;
        poison    <= 1'b0;
      end
      if (beat_ack) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      if ((state == REFILL) && flush) poison <= 1'b1;
      if (fill_ok) begin
        valid[line_idx][vway] <= 1'b1;
        rr[line_idx] <= (rr[line_idx] == LAST_WAY) ? '0 : rr[line_idx] + 1'b1;
      end
      // A flush landing in the same cycle as a fill wins: fill_ok is already blocked
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid[s] <= '0;
      end
    end
  end

  // Storage arrays are left unreset; valid bits guard every read
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (beat_ack) line_buf[beat] <= mem_data;
      if (fill_ok) begin
        tag_mem[line_idx][vway] <= line_tag;
        for (int k = 0; k < LINE_WORDS; k++) data_mem[line_idx][vway][k] <= line_buf[k];
      end
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy) begin
      if (hit && (state == IDLE)) hit_cnt <= hit_cnt + 32'd1;
      if (start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_sa_fetch.sv
// Randomised bench for icache_sa_fetch against a line-granular reference model.
// Build with ICACHE_PERF_EN defined to also cover the performance counters.
module tb_icache_sa_fetch;
  localparam int ADDR_W     = 32;
  localparam int INST_W     = 32;
  localparam int SETS       = 64;
  localparam int WAYS       = 2;
  localparam int LINE_WORDS = 4;
  localparam int LINE_B     = LINE_WORDS * 4;

  logic              clk = 1'b0;
  logic              rst, rdy, flush, stall, mem_req, mem_ack;
  logic [ADDR_W-1:0] pc, pc_o, mem_addr;
  logic [INST_W-1:0] inst_o, mem_data;
`ifdef ICACHE_PERF_EN
  logic [31:0]       hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_sa_fetch #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc(pc), .flush(flush),
    .pc_o(pc_o), .inst_o(inst_o), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: per set, which line address each way holds
  bit          mv    [SETS][WAYS];
  int unsigned mline [SETS][WAYS];
  int          mrr   [SETS];
  int          ph;          // 0 idle, 1 fetching beats, 2 install
  int unsigned r_line;
  int          r_beats, r_vic;
  bit          r_poison;
  int unsigned m_hits, m_miss;
  int          wait_cnt, gap;
  bit          rand_gap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ (a >> 7) ^ 32'hC0DE0000;
  endfunction

  function automatic int set_of(input int unsigned a);
    return int'((a / LINE_B) % SETS);
  endfunction

  function automatic int unsigned line_of(input int unsigned a);
    return a - (a % LINE_B);
  endfunction

  function automatic bit lookup(input int unsigned a);
    int s;
    s = set_of(a);
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mline[s][w] == line_of(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int next_gap();
    return rand_gap ? int'($urandom_range(0, 2)) : gap;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mv[s, w]) mv[s][w] = 1'b0;
    foreach (mrr[s]) mrr[s] = 0;
    ph = 0; r_beats = 0; r_poison = 1'b0; r_line = 0; r_vic = 0;
    m_hits = 0; m_miss = 0;
  endtask

  task automatic model_edge();
    bit h;
    int s;
    if (!rst) begin model_reset(); return; end
    if (!rdy) return;
    h = lookup(pc);
    case (ph)
      0: begin
        if (h) m_hits++;
        if (!h && !flush) begin
          s = set_of(pc);
          r_vic = mrr[s];
          for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) r_vic = w;
          r_line = line_of(pc); r_beats = 0; r_poison = 1'b0; ph = 1; m_miss++;
        end
      end
      1: begin
        if (mem_ack) begin
          r_beats++;
          if (r_beats == LINE_WORDS) ph = 2;
        end
        if (flush) r_poison = 1'b1;
      end
      default: begin
        if (!r_poison && !flush) begin
          s = set_of(r_line);
          mv[s][r_vic] = 1'b1;
          mline[s][r_vic] = r_line;
          mrr[s] = (mrr[s] + 1) % WAYS;
        end
        ph = 0;
      end
    endcase
    if (flush) foreach (mv[s2, w]) mv[s2][w] = 1'b0;
  endtask

  task automatic check_out();
    bit h;
    h = rst && lookup(pc);
    check("stall", stall, !h);
    check("inst_o", inst_o, h ? mem_word(pc) : 32'h0);
    check("pc_o", pc_o, h ? pc : 32'h0);
    check("mem_req", mem_req, ph == 1);
    if (ph == 1) check("mem_addr", mem_addr, r_line + 4 * r_beats);
  endtask

  // One clock: memory responds, outputs sampled at negedge, model advances after the edge
  task automatic cyc();
    if (rst && mem_req && !mem_ack) begin
      if (wait_cnt == 0) begin
        mem_ack  = 1'b1;
        mem_data = mem_word(mem_addr);
      end else wait_cnt--;
    end else if (!mem_req) wait_cnt = next_gap();
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
    model_edge();
    if (mem_ack && rdy) begin
      mem_ack  = 1'b0;
      wait_cnt = next_gap();
    end
  endtask

  task automatic run_idle(input int bound);
    int n;
    n = 0;
    while (ph != 0 && n < bound) begin cyc(); n++; end
    check("refill_timeout", ph, 0);
  endtask

  task automatic wait_beat(input int k);
    int n;
    n = 0;
    while (!(ph == 1 && r_beats == k) && n < 100) begin cyc(); n++; end
    check("reach_beat", r_beats, k);
  endtask

  task automatic fetch(input logic [31:0] a);
    pc = a;
    cyc();
    run_idle(100);
    cyc();
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; pc = '0;
    mem_ack = 1'b0; mem_data = '0;
    gap = 1; rand_gap = 1'b0; wait_cnt = 1;
    model_reset();
    #3;
    check("rst_stall", stall, 1'b1);
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    fetch(32'h0);
    pc = 32'h8; cyc();
    check("hit_no_req", mem_req, 1'b0);

    fetch(32'h400);
    fetch(32'h800);
    pc = 32'h400; cyc();
    pc = 32'h0; cyc();
    check("evicted_refill", mem_req, 1'b1);
    run_idle(100);
    cyc();

    pc = 32'h1000; cyc();
    wait_beat(2);
    flush = 1'b1; cyc(); flush = 1'b0;
    run_idle(100);
    cyc();
    check("poisoned_refetch", mem_req, 1'b1);
    run_idle(100);
    cyc();

    fetch(32'h40);
    pc = 32'h3000; cyc();
    wait_beat(1);
    #2; rst = 1'b0; #1;
    check("async_rst_req", mem_req, 1'b0);
    check("async_rst_stall", stall, 1'b1);
    check("async_rst_addr", mem_addr, 32'h0);
    model_reset();
    mem_ack = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    pc = 32'h40; cyc();
    check("prior_hit_lost", mem_req, 1'b1);
    run_idle(100);
    cyc();

    pc = 32'h2000; cyc();
    wait_beat(1);
    rdy = 1'b0;
    repeat (5) cyc();
    check("rdy_hold_addr", mem_addr, 32'h2004);
    rdy = 1'b1;
    run_idle(100);
    cyc();
    pc = 32'h2004; cyc();
    pc = 32'h2008; cyc();
`ifdef ICACHE_PERF_EN
    check("miss_cnt_dir", miss_cnt, m_miss);
    check("hit_cnt_dir", hit_cnt, m_hits);
`endif

    rand_gap = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int unsigned s, t, wd;
        t  = $urandom_range(0, 3);
        wd = $urandom_range(0, LINE_WORDS - 1);
        case ($urandom_range(0, 2))
          0:       s = 0;
          1:       s = 1;
          default: s = SETS - 1;
        endcase
        pc = (t * SETS * LINE_B) + s * LINE_B + wd * 4;
      end
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 59) == 0);
      cyc();
    end
    flush = 1'b0; rdy = 1'b1;
    run_idle(200);
    cyc();
`ifdef ICACHE_PERF_EN
    check("miss_cnt_rand", miss_cnt, m_miss);
    check("hit_cnt_rand", hit_cnt, m_hits);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
